// File: rtl/fifo_read_stream_adapter_if.sv
// Bundle of the FIFO read port and the outgoing valid/ready stream.
// The adapter sits on the master modport and the FIFO/consumer pair sits on the slave modport.
interface fifo_read_stream_adapter_if #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned BUF_DEPTH  = 4
);
    localparam int unsigned OCC_WIDTH = $clog2(BUF_DEPTH + 1);

    logic                  fifo_empty;
    logic                  fifo_read;
    logic [DATA_WIDTH-1:0] fifo_read_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_data;
    logic [OCC_WIDTH-1:0]  occupancy;

    modport master (
        input  fifo_empty,
        input  fifo_read_data,
        input  out_ready,
        output fifo_read,
        output out_valid,
        output out_data,
        output occupancy
    );

    modport slave (
        output fifo_empty,
        output fifo_read_data,
        output out_ready,
        input  fifo_read,
        input  out_valid,
        input  out_data,
        input  occupancy
    );
endinterface

// File: rtl/fifo_read_stream_adapter.sv
// Turns a fixed-latency FIFO read port into a valid/ready stream.
// A read is issued only when a skid-buffer slot is reserved for it, so a landing word is never dropped.
module fifo_read_stream_adapter #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned LATENCY    = 3,
    parameter int unsigned BUF_DEPTH  = 4
) (
    input logic                        clk,
    input logic                        reset,
    fifo_read_stream_adapter_if.master bus
);
    localparam int unsigned CNT_W = $clog2(BUF_DEPTH + 1);
    localparam int unsigned PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(BUF_DEPTH);
    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(BUF_DEPTH - 1);

    logic [LATENCY-1:0]    valid_q, valid_d;
    logic [CNT_W-1:0]      inflight_q, inflight_d;
    logic [CNT_W-1:0]      buf_count_q, buf_count_d;
    logic [PTR_W-1:0]      rd_idx_q, rd_idx_d;
    logic [PTR_W-1:0]      wr_idx_q, wr_idx_d;
    logic [DATA_WIDTH-1:0] mem_q [BUF_DEPTH];
    logic                  out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;

    logic issue;
    logic land;
    logic pop;

    // Pointers wrap explicitly so non-power-of-two depths work.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == LAST_IDX) begin
            return '0;
        end
        return p + PTR_W'(1);
    endfunction

    assign issue = !reset && !bus.fifo_empty && ((inflight_q + buf_count_q) < DEPTH_C);
    assign land  = valid_q[LATENCY-1];
    assign pop   = out_valid_q && bus.out_ready;

    always_comb begin
        valid_d    = valid_q << 1;
        valid_d[0] = issue;
    end

    always_comb begin
        inflight_d = inflight_q;
        if (issue && !land) begin
            inflight_d = inflight_q + CNT_W'(1);
        end else if (!issue && land) begin
            inflight_d = inflight_q - CNT_W'(1);
        end
    end

    always_comb begin
        buf_count_d = buf_count_q;
        if (land && !pop) begin
            buf_count_d = buf_count_q + CNT_W'(1);
        end else if (pop && !land) begin
            buf_count_d = buf_count_q - CNT_W'(1);
        end
        rd_idx_d = pop  ? ptr_inc(rd_idx_q) : rd_idx_q;
        wr_idx_d = land ? ptr_inc(wr_idx_q) : wr_idx_q;
    end

    // The landing word bypasses the memory when it becomes the new head of an emptied buffer.
    always_comb begin
        out_valid_d = (buf_count_d != '0);
        out_data_d  = out_data_q;
        if (out_valid_d) begin
            if (land && (buf_count_q == CNT_W'(pop))) begin
                out_data_d = bus.fifo_read_data;
            end else begin
                out_data_d = mem_q[rd_idx_d];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q     <= '0;
            inflight_q  <= '0;
            buf_count_q <= '0;
            rd_idx_q    <= '0;
            wr_idx_q    <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            valid_q     <= valid_d;
            inflight_q  <= inflight_d;
            buf_count_q <= buf_count_d;
            rd_idx_q    <= rd_idx_d;
            wr_idx_q    <= wr_idx_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && land) begin
            mem_q[wr_idx_q] <= bus.fifo_read_data;
        end
    end

    assign bus.fifo_read = issue;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.occupancy = inflight_q + buf_count_q;
endmodule
